// File: rtl/alu_multicycle_if.sv
// Handshake bus between issue logic, the multicycle ALU and writeback.
`default_nettype none

interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             carryOut;
  logic             zero;
  logic             overflow;

  modport master (
    output inValid, a, b, op, outReady,
    input  inReady, outValid, result, carryOut, zero, overflow
  );

  modport slave (
    input  inValid, a, b, op, outReady,
    output inReady, outValid, result, carryOut, zero, overflow
  );
endinterface

`default_nettype wire

// File: rtl/alu_multicycle.sv
// ==========================================================================
//  alu_multicycle
//  Registered ALU: single-cycle ADD/SUB/AND/XOR/SLT, shift-add MUL over WIDTH cycles.
//  Revision: 1.0
// ==========================================================================
`default_nettype none

module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         resetN,
  alu_multicycle_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               out_valid;
  logic [WIDTH-1:0]   res;
  logic               carry;
  logic               zflag;
  logic               ovf;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  logic [2*WIDTH-1:0] step_src;
  logic [WIDTH-1:0]   step_m;
  logic               step_bit;
  logic [WIDTH:0]     step_hi;
  logic [2*WIDTH-1:0] step_acc;

  assign bus.inReady  = (state == IDLE);
  assign bus.outValid = out_valid;
  assign bus.result   = res;
  assign bus.carryOut = carry;
  assign bus.zero     = zflag;
  assign bus.overflow = ovf;

  always_comb begin
    add_sum = {1'b0, bus.a} + {1'b0, bus.b};
    sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_sum[WIDTH-1:0];
        alu_c   = sub_sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  // The first shift-add iteration happens on the accept edge so MUL latency is WIDTH.
  always_comb begin
    step_src = (state == IDLE) ? '0 : acc;
    step_m   = (state == IDLE) ? bus.a : mcand;
    step_bit = (state == IDLE) ? bus.b[0] : mplier[0];
    step_hi  = {1'b0, step_src[2*WIDTH-1:WIDTH]} + (step_bit ? {1'b0, step_m} : '0);
    step_acc = {step_hi, step_src[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      carry     <= 1'b0;
      zflag     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inValid) begin
            if (bus.op == OP_MUL) begin
              state  <= MUL;
              mcand  <= bus.a;
              mplier <= bus.b >> 1;
              acc    <= step_acc;
              count  <= CW'(WIDTH - 1);
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              res       <= alu_res;
              carry     <= alu_c;
              zflag     <= (alu_res == '0);
              ovf       <= alu_v;
            end
          end
        end
        MUL: begin
          acc    <= step_acc;
          mplier <= mplier >> 1;
          count  <= count - 1'b1;
          if (count == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            res       <= step_acc[WIDTH-1:0];
            carry     <= |step_acc[2*WIDTH-1:WIDTH];
            zflag     <= (step_acc[WIDTH-1:0] == '0);
            ovf       <= 1'b0;
          end
        end
        DONE: begin
          if (bus.outReady) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32 and WIDTH=8 instances).
`default_nettype none

module tb_alu_multicycle;
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(32)) bus ();
  alu_multicycle_if #(.WIDTH(8))  bus8 ();

  alu_multicycle #(.WIDTH(32)) dut  (.clk(clk), .resetN(resetN), .bus(bus));
  alu_multicycle #(.WIDTH(8))  dut8 (.clk(clk), .resetN(resetN), .bus(bus8));

  int vectors = 0;
  int miscompares = 0;

  // Drive one request on the 32-bit bus, scramble inputs after accept, then
  // measure latency (1 = outValid seen right after the accept edge).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic rdy_seen);
    int guard = 0;
    @(negedge clk);
    while (!bus.inReady && guard < 200) begin @(negedge clk); guard++; end
    bus.op = op; bus.a = a; bus.b = b; bus.inValid = 1'b1;
    @(posedge clk); #1;
    bus.inValid = 1'b0; bus.a = ~a; bus.b = ~b; bus.op = 3'b011;
    lat = 1; rdy_seen = 1'b0;
    while (!bus.outValid && lat < 200) begin
      if (bus.inReady) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #12;
    vectors++;
    if (bus.outValid !== 1'b0 || bus.result !== 32'h0 || bus.carryOut !== 1'b0 ||
        bus.zero !== 1'b0 || bus.overflow !== 1'b0 || bus.inReady !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b r=%h c=%b z=%b o=%b rdy=%b want v=0 r=0 c=0 z=0 o=0 rdy=1",
               bus.outValid, bus.result, bus.carryOut, bus.zero, bus.overflow, bus.inReady);
    end
    @(negedge clk); resetN = 1'b1;
  endtask

  task automatic test_add();
    int lat; logic rs;
    issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, lat, rs);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL add_latency: got %0d want 1", lat); end
    vectors++;
    if ({bus.result, bus.carryOut, bus.zero, bus.overflow} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL add_wrap: got r=%h c=%b z=%b o=%b want r=00000000 c=1 z=1 o=0",
               bus.result, bus.carryOut, bus.zero, bus.overflow);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
      miscompares++;
      $display("FAIL add_one_cycle_valid: got v=%b rdy=%b want v=0 rdy=1", bus.outValid, bus.inReady);
    end
  endtask

  task automatic test_sub();
    int lat; logic rs;
    issue(3'b001, 32'h8000_0000, 32'h0000_0001, lat, rs);
    vectors++;
    if ({bus.result, bus.carryOut, bus.zero, bus.overflow} !== {32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL sub_ovf: got r=%h c=%b z=%b o=%b want r=7fffffff c=1 z=0 o=1",
               bus.result, bus.carryOut, bus.zero, bus.overflow);
    end
    issue(3'b001, 32'h0000_0003, 32'h0000_0005, lat, rs);
    vectors++;
    if ({bus.result, bus.carryOut, bus.zero, bus.overflow} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL sub_borrow: got r=%h c=%b z=%b o=%b want r=fffffffe c=0 z=0 o=0",
               bus.result, bus.carryOut, bus.zero, bus.overflow);
    end
  endtask

  task automatic test_logic();
    int lat; logic rs;
    issue(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, lat, rs);
    vectors++;
    if ({bus.result, bus.carryOut, bus.overflow} !== {32'h1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL slt_true: got r=%h c=%b o=%b want r=1 c=0 o=0", bus.result, bus.carryOut, bus.overflow);
    end
    issue(3'b100, 32'h0000_0001, 32'hFFFF_FFFF, lat, rs);
    vectors++;
    if ({bus.result, bus.zero} !== {32'h0, 1'b1}) begin
      miscompares++; $display("FAIL slt_false: got r=%h z=%b want r=0 z=1", bus.result, bus.zero);
    end
    issue(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, rs);
    vectors++;
    if ({bus.result, bus.zero, bus.carryOut} !== {32'hF000_F000, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL and: got r=%h z=%b c=%b want r=f000f000 z=0 c=0", bus.result, bus.zero, bus.carryOut);
    end
    issue(3'b011, 32'h1234_5678, 32'h1234_5678, lat, rs);
    vectors++;
    if ({bus.result, bus.zero} !== {32'h0, 1'b1}) begin
      miscompares++; $display("FAIL xor_equal: got r=%h z=%b want r=0 z=1", bus.result, bus.zero);
    end
    issue(3'b011, 32'h0000_00FF, 32'h0000_0F0F, lat, rs);
    vectors++;
    if ({bus.result, bus.zero} !== {32'h0000_0FF0, 1'b0}) begin
      miscompares++; $display("FAIL xor: got r=%h z=%b want r=00000ff0 z=0", bus.result, bus.zero);
    end
    issue(3'b110, 32'hDEAD_BEEF, 32'h1234_5678, lat, rs);
    vectors++;
    if (lat !== 1 || {bus.result, bus.zero, bus.carryOut, bus.overflow} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reserved_op: got lat=%0d r=%h z=%b c=%b o=%b want lat=1 r=0 z=1 c=0 o=0",
               lat, bus.result, bus.zero, bus.carryOut, bus.overflow);
    end
  endtask

  task automatic test_mul();
    int lat; logic rs;
    issue(3'b101, 32'd7, 32'd6, lat, rs);
    vectors++;
    if (lat !== 32 || rs !== 1'b0) begin
      miscompares++; $display("FAIL mul_latency: got lat=%0d rdy_seen=%b want lat=32 rdy_seen=0", lat, rs);
    end
    vectors++;
    if ({bus.result, bus.carryOut, bus.zero, bus.overflow} !== {32'h2A, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL mul_7x6: got r=%h c=%b z=%b o=%b want r=0000002a c=0 z=0 o=0",
               bus.result, bus.carryOut, bus.zero, bus.overflow);
    end
    issue(3'b101, 32'h0001_0000, 32'h0001_0000, lat, rs);
    vectors++;
    if ({bus.result, bus.carryOut, bus.zero} !== {32'h0, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL mul_hi_overflow: got r=%h c=%b z=%b want r=0 c=1 z=1", bus.result, bus.carryOut, bus.zero);
    end
    issue(3'b101, 32'h0001_2345, 32'h0000_0100, lat, rs);
    vectors++;
    if ({bus.result, bus.carryOut} !== {32'h0123_4500, 1'b0}) begin
      miscompares++; $display("FAIL mul_shift: got r=%h c=%b want r=01234500 c=0", bus.result, bus.carryOut);
    end
  endtask

  task automatic test_mul8();
    logic [7:0] av [2] = '{8'h0F, 8'hFF};
    logic [7:0] bv [2] = '{8'h11, 8'hFF};
    logic [9:0] ex [2] = '{{8'hFF, 1'b0, 1'b0}, {8'h01, 1'b1, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      int lat;
      @(negedge clk);
      bus8.op = 3'b101; bus8.a = av[i]; bus8.b = bv[i]; bus8.inValid = 1'b1;
      @(posedge clk); #1;
      bus8.inValid = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
      lat = 1;
      while (!bus8.outValid && lat < 100) begin @(posedge clk); #1; lat++; end
      vectors++;
      if (lat !== 8 || {bus8.result, bus8.carryOut, bus8.zero} !== ex[i]) begin
        miscompares++;
        $display("FAIL mul8_%0d: got lat=%0d r=%h c=%b z=%b want lat=8 r=%h c=%b z=%b",
                 i, lat, bus8.result, bus8.carryOut, bus8.zero, ex[i][9:2], ex[i][1], ex[i][0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat; logic rs;
    bus.outReady = 1'b0;
    issue(3'b000, 32'd2, 32'd3, lat, rs);
    vectors++;
    if (lat !== 1 || bus.result !== 32'd5) begin
      miscompares++; $display("FAIL bp_initial: got lat=%0d r=%h want lat=1 r=5", lat, bus.result);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.op = 3'b001; bus.a = 32'd9; bus.b = 32'd1; bus.inValid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({bus.outValid, bus.inReady, bus.result, bus.carryOut, bus.zero, bus.overflow} !==
          {1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_stall_%0d: got v=%b rdy=%b r=%h c=%b z=%b o=%b want v=1 rdy=0 r=5 c=0 z=0 o=0",
                 i, bus.outValid, bus.inReady, bus.result, bus.carryOut, bus.zero, bus.overflow);
      end
    end
    @(negedge clk);
    bus.inValid = 1'b0; bus.outReady = 1'b1;
    vectors++;
    if (bus.inReady !== 1'b0) begin miscompares++; $display("FAIL bp_handshake_cycle_ready: got %b want 0", bus.inReady); end
    @(posedge clk); #1;
    vectors++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1 || bus.result !== 32'd5) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b rdy=%b r=%h want v=0 rdy=1 r=5", bus.outValid, bus.inReady, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.op = 3'b000; bus.a = 32'd10; bus.b = 32'd20; bus.inValid = 1'b1;
    @(posedge clk); #1;
    bus.op = 3'b011; bus.a = 32'hAAAA_0000; bus.b = 32'h0000_5555;
    vectors++;
    if (bus.outValid !== 1'b1 || bus.result !== 32'd30) begin
      miscompares++; $display("FAIL b2b_first: got v=%b r=%h want v=1 r=1e", bus.outValid, bus.result);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.outValid !== 1'b0 || bus.inReady !== 1'b1) begin
      miscompares++; $display("FAIL b2b_gap: got v=%b rdy=%b want v=0 rdy=1", bus.outValid, bus.inReady);
    end
    @(posedge clk); #1;
    bus.inValid = 1'b0;
    vectors++;
    if (bus.outValid !== 1'b1 || bus.result !== 32'hAAAA_5555) begin
      miscompares++; $display("FAIL b2b_second: got v=%b r=%h want v=1 r=aaaa5555", bus.outValid, bus.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    int lat; logic rs; logic seen;
    @(negedge clk);
    bus.op = 3'b101; bus.a = 32'd1000; bus.b = 32'd1000; bus.inValid = 1'b1;
    @(posedge clk); #1;
    bus.inValid = 1'b0;
    repeat (9) @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    vectors++;
    if ({bus.outValid, bus.inReady, bus.result, bus.carryOut, bus.zero, bus.overflow} !==
        {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_mul: got v=%b rdy=%b r=%h c=%b z=%b o=%b want v=0 rdy=1 r=0 c=0 z=0 o=0",
               bus.outValid, bus.inReady, bus.result, bus.carryOut, bus.zero, bus.overflow);
    end
    @(negedge clk); resetN = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.outValid) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_no_valid: got outValid pulse=%b want 0", seen); end
    issue(3'b000, 32'd1, 32'd1, lat, rs);
    vectors++;
    if (lat !== 1 || bus.result !== 32'd2) begin
      miscompares++; $display("FAIL post_reset_add: got lat=%0d r=%h want lat=1 r=2", lat, bus.result);
    end
  endtask

  initial begin
    bus.inValid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.outReady = 1'b1;
    bus8.inValid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.outReady = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_mul8();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered ALU with a valid/ready handshake on both sides. It performs ADD, SUB, AND, XOR and signed SLT in one cycle, and an unsigned shift-add MUL over WIDTH cycles. It replaces the purely combinational 32-bit adder/logic/mux datapath as the execute-stage unit. The upstream issue logic and the downstream writeback stage exchange one operation per handshake with it.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; legal range ≥ 4.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  one clock; reset is asynchronous and active-low.
- inValid  in  1  operation request present.
- inReady  out  1  unit can accept a request; high only in IDLE.
- a  in  WIDTH  operand A, sampled at accept only.
- b  in  WIDTH  operand B, sampled at accept only.
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 SLT, 101 MUL, 110/111 reserved.
- outValid  out  1  result, carryOut, zero and overflow are valid.
- outReady  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- carryOut  out  1  carry/no-borrow/product-overflow flag.
- zero  out  1  result equals 0.
- overflow  out  1  signed overflow flag.

## Operation
- States: IDLE, MUL, DONE.
- Accept occurs on a rising edge with inValid && inReady. a, b and op are latched; later input changes have no effect until the next accept.
- IDLE → DONE on accept of any op other than MUL; result and flags are registered at that edge.
- IDLE → MUL on accept of MUL. The multiplicand, multiplier and a 2·WIDTH accumulator are loaded, with an iteration counter set to WIDTH.
- MUL step, once per cycle:
  - if multiplier LSB = 1, add the multiplicand into the upper half of the accumulator;
  - shift the accumulator right by 1, keeping the adder carry in the MSB;
  - shift the multiplier right by 1 and decrement the counter.
  - On the step where the counter reaches 0, go to DONE and register result and flags.
- DONE → IDLE on outValid && outReady. In DONE, result and flags are held stable.
- Arithmetic rules, all modulo 2^WIDTH:
  - ADD: result = a+b; carryOut = carry out of the MSB; overflow = signed overflow.
  - SUB: result = a + ~b + 1; carryOut = carry out (1 means a ≥ b unsigned); overflow = signed overflow.
  - AND, XOR: bitwise; carryOut = 0; overflow = 0.
  - SLT: result = zero-extended 1-bit (a < b, signed); carryOut = 0; overflow = 0.
  - MUL: result = low WIDTH bits of the unsigned product; carryOut = 1 if the high WIDTH bits are nonzero; overflow = 0.
  - Reserved ops: result = 0, zero = 1, other flags 0, one-cycle latency, no error indication.
- zero = (result == 0) for every op, including MUL.

## Timing
- Reset (resetN low, asynchronous): state IDLE, outValid = 0, result = 0, carryOut = 0, zero = 0, overflow = 0, accumulator and counter = 0.
- inReady is decoded from state, so it is 1 during and immediately after reset.
- Reset mid-MUL or in DONE aborts the operation. No outValid pulse follows; the next accept proceeds normally.
- Latency, counted from the accept edge to outValid high:
  - 1 cycle for non-MUL ops;
  - exactly WIDTH cycles for MUL.
- outValid stays high until the cycle with outReady high. Outputs do not change while outValid && !outReady.
- inReady is low in MUL and DONE, and for the whole cycle in which the output handshake completes. inValid is ignored in those cycles.
- Throughput: at most one non-MUL op per 2 cycles; one MUL per WIDTH+1 cycles.
- If outReady is already high when outValid rises, the output handshake completes on the next edge (outValid high for exactly 1 cycle).
- No combinational path from inputs to outputs.

## Test plan
- ADD, WIDTH=32, a=0xFFFFFFFF, b=0x00000001, outReady=1 → outValid exactly 1 cycle after accept; result=0x00000000, carryOut=1, zero=1, overflow=0.
- SUB, a=0x80000000, b=0x00000001 → result=0x7FFFFFFF, carryOut=1, overflow=1, zero=0.
  - SUB, a=0x00000003, b=0x00000005 → result=0xFFFFFFFE, carryOut=0, overflow=0.
- SLT, a=0xFFFFFFFF, b=0x00000001 → result=0x00000001.
  - Operands swapped → result=0x00000000.
  - AND 0xF0F0F0F0 & 0xFF00FF00 → result=0xF000F000.
  - XOR of equal operands → result=0, zero=1.
- MUL, a=7, b=6 → result=42 (0x0000002A), carryOut=0, outValid exactly 32 cycles after accept, inReady low throughout.
  - MUL, a=0x00010000, b=0x00010000 → result=0, carryOut=1, zero=1.
  - Repeat with WIDTH=8: 0x0F × 0x11 → result=0xFF, carryOut=0, latency 8.
- Backpressure: ADD 2+3 with outReady held low for 5 cycles → result=5 and flags stable, outValid=1, inReady=0.
  - inValid with a new op during the stall is not accepted.
  - Raising outReady completes the handshake; inReady returns 1 on the following cycle.
- Assert resetN low asynchronously (mid-cycle) at cycle 10 of a MUL → all outputs go to reset values immediately, inReady=1, no outValid afterwards.
  - A subsequent ADD 1+1 returns result=2 with 1-cycle latency.
